// File: rtl/fp_shift_pkg.sv
// Shared types and helpers for the floating-point mantissa shift pipeline.
package fp_shift_pkg;

    typedef enum logic [1:0] {
        OP_RDIFF = 2'd0,
        OP_RTGT  = 2'd1,
        OP_LDIFF = 2'd2,
        OP_NORM  = 2'd3
    } fp_op_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fp_flags_t;

    // Wide enough to encode any clamped shift (up to MAN_W) with headroom.
    function automatic int shift_width(input int man_w);
        return $clog2(2 * man_w) + 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt,
    output logic          all_zero
);

    // Later (higher) set bits override earlier ones, leaving the MSB-most position.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

    assign all_zero = ~|din;

endmodule

// File: rtl/fp_shift_pipe.sv
// Two-stage elastic mantissa align/normalise shifter: S1 decodes amount,
// exponent and flags; S2 runs the log-stage barrel shift with sticky loss.
module fp_shift_pipe
    import fp_shift_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [EXP_W-1:0] in_arg,
    input  logic [MAN_W-1:0] in_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_loss,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_zero
);

    localparam int SH_W = shift_width(MAN_W);
    localparam int LZ_W = $clog2(MAN_W + 1);
    localparam logic [MAN_W-1:0] ONES = '1;

    logic s2_load, s1_load;

    // ---------------- S1 decode ----------------
    logic [LZ_W-1:0]  lz_cnt;
    logic             lz_zero;
    logic [EXP_W:0]   rd_sum;
    logic [31:0]      dec_amt;
    logic             dec_left;
    logic [EXP_W-1:0] dec_exp;
    fp_flags_t        dec_flags;
    logic [SH_W-1:0]  dec_sh;

    fp_lzc #(.W(MAN_W), .CW(LZ_W)) u_lzc (
        .din      (in_man),
        .cnt      (lz_cnt),
        .all_zero (lz_zero)
    );

    always_comb begin
        dec_amt   = '0;
        dec_left  = 1'b0;
        dec_exp   = '0;
        dec_flags = '0;
        rd_sum    = {1'b0, in_exp} + {1'b0, in_arg};
        case (fp_op_e'(in_op))
            OP_RDIFF: begin
                dec_exp = rd_sum[EXP_W-1:0];
                // Overflow flushes the mantissa by forcing a full-width right shift,
                // which also yields loss = |in_man for free.
                if (rd_sum[EXP_W] || &rd_sum[EXP_W-1:0]) begin
                    dec_flags.ovf = 1'b1;
                    dec_amt       = 32'(MAN_W);
                end else begin
                    dec_amt = 32'(in_arg);
                end
            end
            OP_RTGT: begin
                dec_exp = in_arg;
                if (in_arg < in_exp) dec_flags.unf = 1'b1;
                else                 dec_amt       = 32'(in_arg - in_exp);
            end
            OP_LDIFF: begin
                dec_left = 1'b1;
                if (in_arg > in_exp) begin
                    dec_flags.unf = 1'b1;
                    dec_amt       = 32'(in_exp);
                end else begin
                    dec_exp = in_exp - in_arg;
                    dec_amt = 32'(in_arg);
                end
            end
            default: begin
                dec_left = 1'b1;
                if (lz_zero) begin
                    dec_flags.zero = 1'b1;
                end else if (32'(lz_cnt) > 32'(in_exp)) begin
                    dec_flags.unf = 1'b1;
                    dec_amt       = 32'(in_exp);
                end else begin
                    dec_exp = in_exp - EXP_W'(lz_cnt);
                    dec_amt = 32'(lz_cnt);
                end
            end
        endcase
        dec_sh = (dec_amt >= 32'(MAN_W)) ? SH_W'(MAN_W) : SH_W'(dec_amt);
    end

    // ---------------- pipeline registers ----------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_left_q,  s1_left_d;
    logic [SH_W-1:0]  s1_sh_q,    s1_sh_d;
    logic [MAN_W-1:0] s1_man_q,   s1_man_d;
    logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
    fp_flags_t        s1_flags_q, s1_flags_d;

    logic             s2_valid_q, s2_valid_d;
    logic [MAN_W-1:0] s2_man_q,   s2_man_d;
    logic [EXP_W-1:0] s2_exp_q,   s2_exp_d;
    logic             s2_loss_q,  s2_loss_d;
    fp_flags_t        s2_flags_q, s2_flags_d;

    logic [MAN_W-1:0] sh_man;
    logic             sh_loss;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Each stage of 2^k collects the bits it pushes out before shifting.
    always_comb begin
        sh_man  = s1_man_q;
        sh_loss = 1'b0;
        for (int k = 0; k < SH_W; k++) begin
            if (s1_sh_q[k]) begin
                if (s1_left_q) begin
                    sh_loss = sh_loss | (|(sh_man & ~(ONES >> (1 << k))));
                    sh_man  = sh_man << (1 << k);
                end else begin
                    sh_loss = sh_loss | (|(sh_man & ~(ONES << (1 << k))));
                    sh_man  = sh_man >> (1 << k);
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_load ? in_valid : s1_valid_q;
        s1_left_d  = s1_left_q;
        s1_sh_d    = s1_sh_q;
        s1_man_d   = s1_man_q;
        s1_exp_d   = s1_exp_q;
        s1_flags_d = s1_flags_q;
        if (s1_load && in_valid) begin
            s1_left_d  = dec_left;
            s1_sh_d    = dec_sh;
            s1_man_d   = in_man;
            s1_exp_d   = dec_exp;
            s1_flags_d = dec_flags;
        end

        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_man_d   = s2_man_q;
        s2_exp_d   = s2_exp_q;
        s2_loss_d  = s2_loss_q;
        s2_flags_d = s2_flags_q;
        if (s2_load && s1_valid_q) begin
            s2_man_d   = sh_man;
            s2_exp_d   = s1_exp_q;
            s2_loss_d  = sh_loss;
            s2_flags_d = s1_flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_left_q  <= 1'b0;
            s1_sh_q    <= '0;
            s1_man_q   <= '0;
            s1_exp_q   <= '0;
            s1_flags_q <= '0;
            s2_valid_q <= 1'b0;
            s2_man_q   <= '0;
            s2_exp_q   <= '0;
            s2_loss_q  <= 1'b0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_left_q  <= s1_left_d;
            s1_sh_q    <= s1_sh_d;
            s1_man_q   <= s1_man_d;
            s1_exp_q   <= s1_exp_d;
            s1_flags_q <= s1_flags_d;
            s2_valid_q <= s2_valid_d;
            s2_man_q   <= s2_man_d;
            s2_exp_q   <= s2_exp_d;
            s2_loss_q  <= s2_loss_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_exp   = s2_exp_q;
    assign out_man   = s2_man_q;
    assign out_loss  = s2_loss_q;
    assign out_ovf   = s2_flags_q.ovf;
    assign out_unf   = s2_flags_q.unf;
    assign out_zero  = s2_flags_q.zero;

endmodule

// File: tb/tb_fp_shift_pipe.sv
// Directed bench for fp_shift_pipe: per-op vectors, latency, backpressure, reset.
module tb_fp_shift_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_exp;
    logic [7:0]  in_arg;
    logic [27:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [27:0] out_man;
    logic        out_loss, out_ovf, out_unf, out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // r = {exp, man, loss, ovf, unf, zero}
    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  e;
        logic [7:0]  a;
        logic [27:0] m;
        logic [39:0] r;
    } vec_t;

    fp_shift_pipe #(.EXP_W(8), .MAN_W(28)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_exp    (in_exp),
        .in_arg    (in_arg),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_man   (out_man),
        .out_loss  (out_loss),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] outs();
        return {out_exp, out_man, out_loss, out_ovf, out_unf, out_zero};
    endfunction

    // Drive one transaction, return the result and edges from accept to out_valid.
    task automatic run_one(input logic [1:0] op, input logic [7:0] e, input logic [7:0] a,
                           input logic [27:0] m, output logic [39:0] got, output int lat);
        int cnt;
        in_op = op; in_exp = e; in_arg = a; in_man = m; in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        got = outs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'd0; in_exp = '0; in_arg = '0; in_man = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, outs()} !== 41'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {out_valid, outs()});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_rdiff();
        vec_t v[5];
        logic [39:0] got; int lat;
        v[0] = '{2'd0, 8'h10, 8'h03, 28'h000000F, {8'h13, 28'h0000001, 4'b1000}};
        v[1] = '{2'd0, 8'hF0, 8'h20, 28'h1234567, {8'h10, 28'h0000000, 4'b1100}};
        v[2] = '{2'd0, 8'hF0, 8'h0F, 28'h0000000, {8'hFF, 28'h0000000, 4'b0100}};
        v[3] = '{2'd0, 8'h10, 8'h40, 28'h0000100, {8'h50, 28'h0000000, 4'b1000}};
        v[4] = '{2'd0, 8'h00, 8'h00, 28'hABCDEF1, {8'h00, 28'hABCDEF1, 4'b0000}};
        for (int i = 0; i < 5; i++) begin
            run_one(v[i].op, v[i].e, v[i].a, v[i].m, got, lat);
            n_checks++;
            if (got !== v[i].r) begin
                n_fail++; $display("FAIL rdiff[%0d]: got %h want %h", i, got, v[i].r);
            end
            n_checks++;
            if (lat != 2) begin
                n_fail++; $display("FAIL rdiff_latency[%0d]: got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_rtgt();
        vec_t v[3];
        logic [39:0] got; int lat;
        v[0] = '{2'd1, 8'h20, 8'h1F, 28'hABCDEF0, {8'h1F, 28'hABCDEF0, 4'b0010}};
        v[1] = '{2'd1, 8'h10, 8'h14, 28'h00000FF, {8'h14, 28'h000000F, 4'b1000}};
        v[2] = '{2'd1, 8'h10, 8'h10, 28'h8000001, {8'h10, 28'h8000001, 4'b0000}};
        for (int i = 0; i < 3; i++) begin
            run_one(v[i].op, v[i].e, v[i].a, v[i].m, got, lat);
            n_checks++;
            if (got !== v[i].r || lat != 2) begin
                n_fail++; $display("FAIL rtgt[%0d]: got %h lat %0d want %h lat 2", i, got, lat, v[i].r);
            end
        end
    endtask

    task automatic test_ldiff();
        vec_t v[3];
        logic [39:0] got; int lat;
        v[0] = '{2'd2, 8'h10, 8'h04, 28'hF000001, {8'h0C, 28'h0000010, 4'b1000}};
        v[1] = '{2'd2, 8'h02, 8'h05, 28'h0000001, {8'h00, 28'h0000004, 4'b0010}};
        v[2] = '{2'd2, 8'h40, 8'h03, 28'h0000003, {8'h3D, 28'h0000018, 4'b0000}};
        for (int i = 0; i < 3; i++) begin
            run_one(v[i].op, v[i].e, v[i].a, v[i].m, got, lat);
            n_checks++;
            if (got !== v[i].r || lat != 2) begin
                n_fail++; $display("FAIL ldiff[%0d]: got %h lat %0d want %h lat 2", i, got, lat, v[i].r);
            end
        end
    endtask

    task automatic test_norm();
        vec_t v[5];
        logic [39:0] got; int lat;
        v[0] = '{2'd3, 8'h40, 8'hAA, 28'h0001000, {8'h31, 28'h8000000, 4'b0000}};
        v[1] = '{2'd3, 8'h05, 8'hAA, 28'h0001000, {8'h00, 28'h0020000, 4'b0010}};
        v[2] = '{2'd3, 8'h40, 8'hAA, 28'h0000000, {8'h00, 28'h0000000, 4'b0001}};
        v[3] = '{2'd3, 8'h0F, 8'hAA, 28'h0001000, {8'h00, 28'h8000000, 4'b0000}};
        v[4] = '{2'd3, 8'h03, 8'hAA, 28'h8000000, {8'h03, 28'h8000000, 4'b0000}};
        for (int i = 0; i < 5; i++) begin
            run_one(v[i].op, v[i].e, v[i].a, v[i].m, got, lat);
            n_checks++;
            if (got !== v[i].r || lat != 2) begin
                n_fail++; $display("FAIL norm[%0d]: got %h lat %0d want %h lat 2", i, got, lat, v[i].r);
            end
        end
    endtask

    // Four LDIFFs on consecutive cycles with out_ready high: full rate in and out.
    task automatic test_back_to_back();
        logic [36:0] want;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                in_valid = 1'b1; in_op = 2'd2; in_exp = 8'h20 + 8'(cyc);
                in_arg = 8'(cyc); in_man = 28'h1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 4) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready);
                end
            end
            if (cyc >= 2) begin
                want = {1'b1, 8'h20, 28'h1 << (cyc - 2)};
                n_checks++;
                if ({out_valid, out_exp, out_man} !== want) begin
                    n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", cyc, {out_valid, out_exp, out_man}, want);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // out_ready held low for 4 cycles of valid output while inputs keep coming.
    task automatic test_backpressure();
        int sent, recv;
        bit drop_seen, prev_hold, in_fire, out_fire;
        logic [40:0] prev;
        logic [35:0] want;
        sent = 0; recv = 0; drop_seen = 0; prev_hold = 0; prev = '0;
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            out_ready = (cyc >= 6);
            if (sent < 4) begin
                in_valid = 1'b1; in_op = 2'd0; in_exp = 8'h10 + 8'(sent);
                in_arg = 8'h01; in_man = 28'(4 * (sent + 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (sent == 2 && !drop_seen) begin
                drop_seen = 1;
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_in_ready_drop: got %b want 0", in_ready);
                end
            end
            if (prev_hold) begin
                n_checks++;
                if ({out_valid, outs()} !== prev) begin
                    n_fail++; $display("FAIL bp_hold_stable[%0d]: got %h want %h", cyc, {out_valid, outs()}, prev);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev      = {out_valid, outs()};
            in_fire   = in_valid && in_ready;
            out_fire  = out_valid && out_ready;
            if (out_fire) begin
                want = {8'h11 + 8'(recv), 28'(2 * (recv + 1))};
                n_checks++;
                if ({out_exp, out_man} !== want) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", recv, {out_exp, out_man}, want);
                end
                recv++;
            end
            @(posedge clk); #1;
            if (in_fire) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (recv != 4) begin
            n_fail++; $display("FAIL bp_count: got %0d want 4", recv);
        end
    endtask

    // Two transactions in flight when reset hits: neither may emerge.
    task automatic test_reset_midflight();
        bit stale;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_op = 2'd0; in_exp = 8'h30; in_arg = 8'h00; in_man = 28'h5;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_valid: got %b want 0", out_valid);
        end
        rst = 1'b0;
        stale = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1;
        end
        n_checks++;
        if (stale || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_stale: stale %b in_ready %b want 0/1", stale, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rdiff();
        test_rtgt();
        test_ldiff();
        test_norm();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
